// File: rtl/decode_stage_if.sv
// decode_stage_if: bundles every decode-stage signal except clk/rst_n.
//   fetch side  : if_valid, if_inst -> decode ; if_ready <- decode
//   reg file    : a_addr, b_addr <- decode ; ref_a, ref_b -> decode
//   control     : flush, ex_ready -> decode
//   ID/EX side  : ex_valid, ex_op, ex_rd, ex_rs, ex_rt, ex_opa, ex_opb,
//                 ex_imm, ex_rwe, ex_mre, ex_mwe, illegal_op <- decode
// modport slave is the decode stage; modport master is its environment.
interface decode_stage_if;
  logic        if_valid;
  logic [15:0] if_inst;
  logic        if_ready;
  logic [2:0]  a_addr;
  logic [2:0]  b_addr;
  logic [15:0] ref_a;
  logic [15:0] ref_b;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [2:0]  ex_rd;
  logic [2:0]  ex_rs;
  logic [2:0]  ex_rt;
  logic [15:0] ex_opa;
  logic [15:0] ex_opb;
  logic [15:0] ex_imm;
  logic        ex_rwe;
  logic        ex_mre;
  logic        ex_mwe;
  logic        illegal_op;

  modport slave (
    input  if_valid, if_inst, ref_a, ref_b, flush, ex_ready,
    output if_ready, a_addr, b_addr, ex_valid, ex_op, ex_rd, ex_rs, ex_rt,
           ex_opa, ex_opb, ex_imm, ex_rwe, ex_mre, ex_mwe, illegal_op
  );

  modport master (
    output if_valid, if_inst, ref_a, ref_b, flush, ex_ready,
    input  if_ready, a_addr, b_addr, ex_valid, ex_op, ex_rd, ex_rs, ex_rt,
           ex_opa, ex_opb, ex_imm, ex_rwe, ex_mre, ex_mwe, illegal_op
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: instruction decode for the 16-bit, 8-register pipeline.
// Decodes if_inst, drives register-file read addresses combinationally,
// and captures operands/controls/immediate into the ID/EX register.
// Owns the load-use interlock, the ex_ready backpressure and flush.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   dif   - decode_stage_if.slave (fetch, reg-file, ID/EX signals)
// Build option: DECODE_ILLEGAL_TRAP_EN turns opcodes 9-15 into bubbles and
// sets the sticky illegal_op flag; without it they pass as valid NOPs.
module decode_stage (
  input  logic           clk,
  input  logic           rst_n,
  decode_stage_if.slave  dif
);

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [15:0] imm;
    logic        rwe;
    logic        mre;
    logic        mwe;
  } idex_t;

  idex_t idex_q, idex_d, dec;

  logic [3:0]  op;
  logic [2:0]  rd, rs, rt, b_addr;
  logic        uses_a, uses_b, rwe, mre, mwe;
  logic [15:0] imm;
  logic        advance, stall;

  assign op = dif.if_inst[15:12];
  assign rd = dif.if_inst[11:9];
  assign rs = dif.if_inst[8:6];
  assign rt = dif.if_inst[5:3];

  // Opcode decode; NOP and 9-15 fall through with everything low.
  always_comb begin
    uses_a = 1'b0;
    uses_b = 1'b0;
    rwe    = 1'b0;
    mre    = 1'b0;
    mwe    = 1'b0;
    case (op)
      4'd1, 4'd2, 4'd3, 4'd4: begin uses_a = 1'b1; uses_b = 1'b1; rwe = 1'b1; end
      4'd5:                   begin uses_a = 1'b1; rwe = 1'b1; end
      4'd6:                   begin uses_a = 1'b1; rwe = 1'b1; mre = 1'b1; end
      4'd7:                   begin uses_a = 1'b1; uses_b = 1'b1; mwe = 1'b1; end
      4'd8:                   rwe = 1'b1;
      default: ;
    endcase
  end

  // ST reads its store data through port B from the rd field.
  assign b_addr = (op == 4'd7) ? rd : rt;
  assign imm    = (op == 4'd8) ? {{7{dif.if_inst[8]}}, dif.if_inst[8:0]}
                               : {{10{dif.if_inst[5]}}, dif.if_inst[5:0]};

  assign dif.a_addr = rs;
  assign dif.b_addr = b_addr;

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.op    = op;
    dec.rd    = rd;
    dec.rs    = rs;
    dec.rt    = b_addr;
    dec.opa   = dif.ref_a;
    dec.opb   = dif.ref_b;
    dec.imm   = imm;
    dec.rwe   = rwe;
    dec.mre   = mre;
    dec.mwe   = mwe;
  end

  // Load-use: the LD in ID/EX has no data yet, so a dependent consumer
  // waits one cycle and then reads it through the reg-file bypass.
  assign advance = !idex_q.valid || dif.ex_ready;
  assign stall   = dif.if_valid && idex_q.valid && idex_q.mre &&
                   ((uses_a && (rs == idex_q.rd)) || (uses_b && (b_addr == idex_q.rd)));
  assign dif.if_ready = dif.flush || (advance && !stall);

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  always_comb begin
    idex_d = idex_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    if (dif.flush) begin
      idex_d = '0;
    end else if (!advance) begin
      idex_d = idex_q;  // backpressure: hold
    end else if (stall) begin
      idex_d = '0;      // bubble
    end else if (dif.if_valid) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      if (op >= 4'd9) begin
        idex_d    = '0;
        illegal_d = 1'b1;
      end else begin
        idex_d = dec;
      end
`else
      idex_d = dec;
`endif
    end else begin
      idex_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end
  assign dif.illegal_op = illegal_q;
`else
  assign dif.illegal_op = 1'b0;
`endif

  assign dif.ex_valid = idex_q.valid;
  assign dif.ex_op    = idex_q.op;
  assign dif.ex_rd    = idex_q.rd;
  assign dif.ex_rs    = idex_q.rs;
  assign dif.ex_rt    = idex_q.rt;
  assign dif.ex_opa   = idex_q.opa;
  assign dif.ex_opb   = idex_q.opb;
  assign dif.ex_imm   = idex_q.imm;
  assign dif.ex_rwe   = idex_q.rwe;
  assign dif.ex_mre   = idex_q.mre;
  assign dif.ex_mwe   = idex_q.mwe;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors with hand-computed expected ID/EX
// contents. The driver pushes the expected record when fetch sees its
// instruction accepted; a monitor pops and compares on each ID/EX -> EX
// transfer (ex_valid && ex_ready && !flush). Control-path behaviour
// (stall, backpressure, flush, reset, illegal flag) is checked directly.
module tb_decode_stage;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [15:0] imm;
    logic        rwe;
    logic        mre;
    logic        mwe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  decode_stage_if dif ();

  decode_stage u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dif   (dif)
  );

  always #5 clk = ~clk;

  exp_t expq[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [3:0] op, input logic [2:0] rd, rs, rt,
                              input logic [15:0] opa, opb, imm,
                              input logic rwe, mre, mwe);
    exp_t e;
    e = '{op, rd, rs, rt, opa, opb, imm, rwe, mre, mwe};
    return e;
  endfunction

  // Present one instruction from negedge until accepted at a posedge.
  task automatic send(input logic [15:0] inst, input logic [15:0] ra, rb, output int waits);
    logic acc;
    waits         = 0;
    dif.if_valid  = 1'b1;
    dif.if_inst   = inst;
    dif.ref_a     = ra;
    dif.ref_b     = rb;
    forever begin
      #1;
      acc = dif.if_ready;
      @(posedge clk);
      if (acc) break;
      waits++;
      if (waits > 20) begin
        check($sformatf("accept timeout %h", inst), 64'(waits), 64'd0);
        break;
      end
      @(negedge clk);
    end
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t got, e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && dif.ex_valid && dif.ex_ready && !dif.flush) begin
        got = '{dif.ex_op, dif.ex_rd, dif.ex_rs, dif.ex_rt, dif.ex_opa, dif.ex_opb,
                dif.ex_imm, dif.ex_rwe, dif.ex_mre, dif.ex_mwe};
        if (expq.size() == 0) begin
          check("unexpected transfer", 64'(got), 64'd0);
        end else begin
          e = expq.pop_front();
          check($sformatf("xfer op%0h", e.op), 64'(got), 64'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n        = 1'b0;
    dif.if_valid = 1'b0;
    dif.if_inst  = '0;
    dif.ref_a    = '0;
    dif.ref_b    = '0;
    dif.flush    = 1'b0;
    dif.ex_ready = 1'b1;
    #1;
    check("rst if_ready",   64'(dif.if_ready),   64'd1);
    check("rst ex_valid",   64'(dif.ex_valid),   64'd0);
    check("rst ex_op",      64'(dif.ex_op),      64'd0);
    check("rst ex_imm",     64'(dif.ex_imm),     64'd0);
    check("rst ex_rwe",     64'(dif.ex_rwe),     64'd0);
    check("rst illegal_op", 64'(dif.illegal_op), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ADD r3,r1,r2
    @(negedge clk);
    send(16'h1650, 16'h0005, 16'h0007, w);
    expq.push_back(mk(4'd1, 3'd3, 3'd1, 3'd2, 16'h0005, 16'h0007, 16'h0010, 1, 0, 0));
    #1 check("latency ex_valid", 64'(dif.ex_valid), 64'd1);

    // LD r2,[r1+3] then dependent ADD r4,r2,r1
    @(negedge clk);
    send(16'h6443, 16'h0100, 16'h0200, w);
    expq.push_back(mk(4'd6, 3'd2, 3'd1, 3'd0, 16'h0100, 16'h0200, 16'h0003, 1, 1, 0));
    @(negedge clk);
    dif.if_inst = 16'h1888;
    dif.ref_a   = 16'h0033;
    dif.ref_b   = 16'h0044;
    #1 check("load-use if_ready", 64'(dif.if_ready), 64'd0);
    @(negedge clk);
    #1;
    check("load-use bubble", 64'(dif.ex_valid), 64'd0);
    check("post-bubble ready", 64'(dif.if_ready), 64'd1);
    @(posedge clk);
    expq.push_back(mk(4'd1, 3'd4, 3'd2, 3'd1, 16'h0033, 16'h0044, 16'h0008, 1, 0, 0));

    // ST r5,[r1-1]
    @(negedge clk);
    send(16'h7A7F, 16'h0011, 16'h0055, w);
    expq.push_back(mk(4'd7, 3'd5, 3'd1, 3'd5, 16'h0011, 16'h0055, 16'hFFFF, 0, 0, 1));
    #1 check("st b_addr", 64'(dif.b_addr), 64'd5);

    // LI r6,-256
    @(negedge clk);
    send(16'h8D00, 16'hAAAA, 16'hBBBB, w);
    expq.push_back(mk(4'd8, 3'd6, 3'd4, 3'd0, 16'hAAAA, 16'hBBBB, 16'hFF00, 1, 0, 0));

    // SUB r5,r1,r3 then backpressure for 3 cycles with OR r7,r6,r5 waiting
    @(negedge clk);
    send(16'h2A58, 16'h1234, 16'h5678, w);
    expq.push_back(mk(4'd2, 3'd5, 3'd1, 3'd3, 16'h1234, 16'h5678, 16'h0018, 1, 0, 0));
    @(negedge clk);
    dif.ex_ready = 1'b0;
    dif.if_inst  = 16'h4FA8;
    dif.ref_a    = 16'h0077;
    dif.ref_b    = 16'h0088;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d if_ready", i), 64'(dif.if_ready), 64'd0);
      check($sformatf("bp%0d ex_op", i),    64'(dif.ex_op),    64'd2);
      check($sformatf("bp%0d ex_opa", i),   64'(dif.ex_opa),   64'h1234);
      @(negedge clk);
    end
    dif.ex_ready = 1'b1;
    #1 check("bp release ready", 64'(dif.if_ready), 64'd1);
    @(posedge clk);
    expq.push_back(mk(4'd4, 3'd7, 3'd6, 3'd5, 16'h0077, 16'h0088, 16'hFFE8, 1, 0, 0));

    // Flush kills OR in ID/EX and the presented AND r1,r2,r3
    @(negedge clk);
    dif.ex_ready = 1'b0;
    dif.flush    = 1'b1;
    dif.if_inst  = 16'h3298;
    dif.ref_a    = 16'hDEAD;
    dif.ref_b    = 16'hBEEF;
    #1 check("flush if_ready", 64'(dif.if_ready), 64'd1);
    @(posedge clk);
    void'(expq.pop_back());
    @(negedge clk);
    dif.flush    = 1'b0;
    dif.if_valid = 1'b0;
    dif.ex_ready = 1'b1;
    #1 check("flush ex_valid", 64'(dif.ex_valid), 64'd0);

    // ADDI r1,r7,-32
    @(negedge clk);
    send(16'h53E0, 16'h0700, 16'h0400, w);
    expq.push_back(mk(4'd5, 3'd1, 3'd7, 3'd4, 16'h0700, 16'h0400, 16'hFFE0, 1, 0, 0));

    // Illegal opcode
    @(negedge clk);
    send(16'hF000, 16'h0000, 16'h0000, w);
`ifdef DECODE_ILLEGAL_TRAP_EN
    @(negedge clk);
    dif.if_valid = 1'b0;
    #1;
    check("illegal ex_valid", 64'(dif.ex_valid),   64'd0);
    check("illegal set",      64'(dif.illegal_op), 64'd1);
    repeat (3) @(negedge clk);
    #1 check("illegal sticky", 64'(dif.illegal_op), 64'd1);
    rst_n = 1'b0;
    #1 check("illegal cleared", 64'(dif.illegal_op), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
`else
    expq.push_back(mk(4'hF, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
    @(negedge clk);
    dif.if_valid = 1'b0;
    #1;
    check("illegal ex_valid", 64'(dif.ex_valid),   64'd1);
    check("illegal_op low",   64'(dif.illegal_op), 64'd0);
`endif

    // Reset during backpressure clears ID/EX immediately
    repeat (2) @(negedge clk);
    dif.ex_ready = 1'b0;
    send(16'h1650, 16'h0005, 16'h0007, w);
    @(negedge clk);
    dif.if_valid = 1'b0;
    #1 check("bp held ex_valid", 64'(dif.ex_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid-bp rst ex_valid", 64'(dif.ex_valid), 64'd0);
    check("mid-bp rst ex_rwe",   64'(dif.ex_rwe),   64'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    dif.ex_ready = 1'b1;

    repeat (4) @(negedge clk);
    check("scoreboard drained", 64'(expq.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
